// File: rtl/stack_arb.sv
// stack_arb: two-requester round-robin arbiter in front of a single-port LIFO stack
// Ports: clk/reset (async active-high); req_valid/req_push/req_data0/req_data1 in,
//   req_ready out (handshake); rsp_valid/rsp_id/rsp_data/err out (results);
//   depth/full/empty out (occupancy); stk_en/stk_wen/stk_din out, stk_dout in (stack).
// Macro STACK_ARB_FIXED_PRIO_EN: requester 0 always wins contention, no round-robin pointer.
module stack_arb #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4,
  localparam int DW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_push,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             err,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             stk_en,
  output logic             stk_wen,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  state_t state, nxt;
  logic op_q, own_q, illegal;
  logic [WIDTH-1:0] data_q;
  logic [1:0] gnt;
`ifdef STACK_ARB_FIXED_PRIO_EN
  always_comb gnt = req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
`else
  // last_q is the requester granted most recently; reset to 1 so requester 0 wins first
  logic last_q;
  always_comb gnt = &req_valid ? (last_q ? 2'b01 : 2'b10) : req_valid;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_q <= 1'b1;
    else if (state == IDLE && |req_valid) last_q <= gnt[1];
`endif
  // an operation is illegal when it would overflow or underflow the stack
  always_comb illegal = op_q ? full : empty;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |req_valid ? ISSUE : IDLE;
      ISSUE:   nxt = (illegal || op_q) ? IDLE : CAPTURE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE ? gnt : 2'b00;
    stk_en    = state == ISSUE && !illegal;
    stk_wen   = stk_en && op_q;
    stk_din   = stk_en ? data_q : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_q      <= 1'b0;
      own_q     <= 1'b0;
      data_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
      depth     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      rsp_valid <= state == CAPTURE;
      err       <= state == ISSUE && illegal;
      if (state == IDLE && |req_valid) begin
        op_q   <= gnt[1] ? req_push[1] : req_push[0];
        data_q <= gnt[1] ? req_data1 : req_data0;
        own_q  <= gnt[1];
      end
      if (state == CAPTURE) begin
        rsp_data <= stk_dout;
        rsp_id   <= own_q;
      end
      if (state == ISSUE && illegal) rsp_id <= own_q;
      // depth, full and empty move together so they always agree
      if (stk_en) begin
        depth <= op_q ? depth + 1'b1 : depth - 1'b1;
        full  <= op_q && depth == DW'(DEPTH - 1);
        empty <= !op_q && depth == DW'(1);
      end
    end
endmodule

// File: doc/stack_arb.md
STACK_ARB -- requirements
Module: stack_arb

Interface
REQ-001 Parameter: DEPTH, 8, stack capacity in entries; SHALL match the attached stack.
REQ-002 Parameter: WIDTH, 4, data width in bits.
REQ-003 Port: clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-006 Port: req_push  in  2  per-requester operation: 1 = push, 0 = pop.
REQ-007 Port: req_data0, req_data1  in  WIDTH  push data for requester 0 and requester 1.
REQ-008 Port: req_ready  out  2  per-requester accept strobe; a transfer occurs when valid and ready are both high.
REQ-009 Port: rsp_valid  out  1  one-cycle pop-data strobe.
REQ-010 Port: rsp_id  out  1  requester that owns the current rsp or err.
REQ-011 Port: rsp_data  out  WIDTH  popped value.
REQ-012 Port: err  out  1  one-cycle strobe for overflow or underflow.
REQ-013 Port: depth  out  clog2(DEPTH)+1  current occupancy.
REQ-014 Port: full, empty  out  1  set when depth==DEPTH and depth==0 respectively.
REQ-015 Port: stk_en, stk_wen  out  1  stack command; stk_en=1 with stk_wen=1 is a push, with stk_wen=0 a pop.
REQ-016 Port: stk_din  out  WIDTH  data written to the stack.
REQ-017 Port: stk_dout  in  WIDTH  stack output, valid from the cycle after the edge that executed a pop.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE and CAPTURE.
REQ-019 IDLE: if any req_valid is set, grant one requester, pulse its req_ready for that cycle only, latch op and data, then go to ISSUE; otherwise stay in IDLE.
REQ-020 req_ready SHALL be zero outside IDLE and SHALL never be set for both requesters in the same cycle.
REQ-021 Arbitration SHALL be round-robin: on contention, the requester not granted last wins; the pointer updates only on a grant.
REQ-022 Requesters SHALL hold req_valid, req_push and req_data stable until accepted; the block SHALL NOT depend on any other behaviour.
REQ-023 ISSUE, legal operation: stk_en=1 for exactly one cycle, stk_wen=op, stk_din=latched data; depth increments on push and decrements on pop at the end of ISSUE.
REQ-024 ISSUE, push with full=1 or pop with empty=1: stk_en=0, depth unchanged, err=1 with rsp_id=owner in the next cycle for one cycle, no rsp_valid, next state IDLE.
REQ-025 After a legal push, the next state SHALL be IDLE, giving 2 cycles per push.
REQ-026 After a legal pop, the next state SHALL be CAPTURE; CAPTURE registers stk_dout, and rsp_valid=1 with rsp_data and rsp_id appears in the following cycle for one cycle, giving 3 cycles per pop.
REQ-027 Pop latency SHALL be: rsp_valid asserts exactly 3 cycles after the req_ready cycle.
REQ-028 full, empty and depth SHALL be registered and consistent with each other in every cycle.
REQ-029 rsp_valid and err SHALL never both be 1 in the same cycle.

Reset
REQ-030 While reset=1, asynchronously: state=IDLE, depth=0, empty=1, full=0, all strobes, stk_* outputs and rsp_data=0, round-robin pointer set so that requester 0 wins first.
REQ-031 Reset mid-operation SHALL abort the operation with no rsp_valid or err; the stack SHALL share the same reset so that depth=0 stays consistent with it.

Configuration
REQ-032 Macro STACK_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win contention and the round-robin pointer is removed; when undefined, REQ-021 applies.

Verification
REQ-033 Reset, then requester 0 pushes F, 7, A in turn -> depth=3, stk_en pulses with stk_din F, 7, A, no err.
REQ-034 After REQ-033, requester 1 pops three times -> rsp_data A, 7, F, rsp_id=1, each 3 cycles after req_ready, then empty=1.
REQ-035 Push 8 values, then a 9th push -> full=1, err=1 with rsp_id set, no stk_en, depth stays 8; pop on empty -> err=1, no rsp_valid.
REQ-036 Both requesters hold pushes continuously -> grants alternate 0,1,0,1; with STACK_ARB_FIXED_PRIO_EN defined, requester 0 gets every grant.
REQ-037 Assert reset during a pop's CAPTURE state -> no rsp_valid, depth=0, empty=1, and the next grant goes to requester 0.
